// File: rtl/hwterm_pkg.sv
// hwterm_pkg: types, constants and small helpers shared by the hardware
// terminal blocks (UART receiver state encoding, default bit timing).
package hwterm_pkg;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  // 2-of-3 vote used for mid-bit sampling
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even parity: data bits and parity bit must XOR to zero
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: generic two-flop synchroniser for asynchronous pin inputs.
// Both stages reset to RST_VAL so an idle-high line does not look like
// activity straight out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit serial receiver, LSB first, one stop bit, idle-high line.
// The line is synchronised, every bit is 2-of-3 voted around mid-bit and
// results leave as registered one-cycle strobes.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit (default build is 8N1).
module uart_rx
  import hwterm_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_v,
  output logic       o_frame_err,
  output logic       o_break,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_MAJ  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

  uart_rx_state_t state, state_next;

  logic          rx_s;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          samp0, samp0_next;
  logic          samp1, samp1_next;
  logic          maj, at_maj, at_end;
  logic          par_good;

  logic [7:0]    byte_next;
  logic          byte_v_next, frame_err_next, break_next, parity_err_next, busy_next;

`ifdef UART_RX_PARITY_EN
  logic par, par_next;
  assign par_good = even_parity_ok(shreg, par);
`else
  assign par_good = 1'b1;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_rx),
    .q   (rx_s)
  );

  // third vote comes straight from the line in the evaluation cycle
  assign maj     = maj3(samp0, samp1, rx_s);
  assign at_maj  = (cnt == CNT_MAJ);
  assign at_end  = (cnt == CNT_END);
  assign cnt_inc = at_end ? CNT_ZERO : (cnt + CNT_ONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state decision
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
        else       state_next = IDLE;
      end
      START: begin
        if (at_maj && maj) state_next = IDLE;
        else if (at_end)   state_next = DATA;
        else               state_next = START;
      end
      DATA: begin
        if (at_end && (idx == 3'd7)) state_next = AFTER_DATA;
        else                         state_next = DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_end) state_next = STOP;
        else        state_next = PARITY;
      end
`endif
      STOP: begin
        if (at_maj) state_next = maj ? IDLE : WAIT_IDLE;
        else        state_next = STOP;
      end
      WAIT_IDLE: begin
        if (rx_s) state_next = IDLE;
        else      state_next = WAIT_IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // datapath and strobe values for the next cycle
  always_comb begin
    cnt_next        = cnt_inc;
    idx_next        = idx;
    shreg_next      = shreg;
    samp0_next      = (cnt == CNT_S0) ? rx_s : samp0;
    samp1_next      = (cnt == CNT_S1) ? rx_s : samp1;
`ifdef UART_RX_PARITY_EN
    par_next        = par;
`endif
    byte_next       = o_byte;
    byte_v_next     = 1'b0;
    frame_err_next  = 1'b0;
    break_next      = 1'b0;
    parity_err_next = 1'b0;
    case (state)
      IDLE: begin
        idx_next = 3'd0;
        // the detection cycle itself is cnt = 0 of the start bit
        if (!rx_s) cnt_next = CNT_ONE;
        else       cnt_next = CNT_ZERO;
      end
      START: begin
        idx_next = 3'd0;
        if (at_maj && maj) cnt_next = CNT_ZERO;
        else               cnt_next = cnt_inc;
      end
      DATA: begin
        if (at_maj) shreg_next[idx] = maj;
        else        shreg_next = shreg;
        if (at_end) idx_next = idx + 3'd1;
        else        idx_next = idx;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_maj) par_next = maj;
        else        par_next = par;
      end
`endif
      STOP: begin
        if (at_maj) begin
          cnt_next = CNT_ZERO;
          if (maj) begin
            if (par_good) begin
              byte_next   = shreg;
              byte_v_next = 1'b1;
            end else begin
              parity_err_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
            break_next     = (shreg == 8'h00);
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end
      WAIT_IDLE: begin
        cnt_next = CNT_ZERO;
      end
      default: begin
        cnt_next = CNT_ZERO;
        idx_next = 3'd0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // bit timing, index, shift register and vote samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= CNT_ZERO;
      idx   <= 3'd0;
      shreg <= 8'h00;
      samp0 <= 1'b1;
      samp1 <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
      samp0 <= samp0_next;
      samp1 <= samp1_next;
`ifdef UART_RX_PARITY_EN
      par   <= par_next;
`endif
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      o_byte       <= 8'h00;
      o_byte_v     <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_parity_err <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_byte       <= byte_next;
      o_byte_v     <= byte_v_next;
      o_frame_err  <= frame_err_next;
      o_break      <= break_next;
      o_parity_err <= parity_err_next;
      o_busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized stimulus for uart_rx. The driven
// line and reset are logged per cycle; a reference model replays that log
// with the frame timing rules (sample instants, 2-of-3 votes) to predict
// every strobe, which is compared against what the DUT produced.
module tb_uart_rx;

  localparam int C = 104;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int STOP_K = NBITS - 1;
  localparam int MAXC   = 90000;
  localparam int K_BYTE = 0, K_FERR = 1, K_BRK = 2, K_PERR = 3, K_ANY = -1;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx;
  logic [7:0] o_byte;
  logic       o_byte_v, o_frame_err, o_break, o_parity_err, o_busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .o_byte       (o_byte),
    .o_byte_v     (o_byte_v),
    .o_frame_err  (o_frame_err),
    .o_break      (o_break),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int kind; int data;} ev_t;
  ev_t  got[$];
  ev_t  exp_q[$];
  logic line_rec [MAXC];
  logic rst_rec  [MAXC];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // cycle number: cycle c is the interval after the c-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // log the line and reset of each cycle, collect DUT strobes
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      line_rec[cyc] <= i_rx;
      rst_rec[cyc]  <= rst;
    end
    if (o_byte_v === 1'b1)     got.push_back('{cyc: cyc, kind: K_BYTE, data: int'(o_byte)});
    if (o_frame_err === 1'b1)  got.push_back('{cyc: cyc, kind: K_FERR, data: 0});
    if (o_break === 1'b1)      got.push_back('{cyc: cyc, kind: K_BRK,  data: 0});
    if (o_parity_err === 1'b1) got.push_back('{cyc: cyc, kind: K_PERR, data: 0});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip,
                            input bit jit);
    logic lv;
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0)               lv = 1'b0;
      else if (k <= 8)          lv = b[k-1];
      else if (k == NBITS - 1)  lv = stop_v;
      else                      lv = (^b) ^ par_flip;
      i_rx = lv;
      if (jit) tick(C + int'($urandom_range(4, 0)) - 2);
      else     tick(C);
    end
  endtask

  function automatic int count_ev(input int kind, input int from, input int to);
    int n = 0;
    foreach (got[i])
      if ((kind == K_ANY || got[i].kind == kind) && got[i].cyc >= from && got[i].cyc <= to) n++;
    return n;
  endfunction

  function automatic int first_ev(input int kind, input int from);
    foreach (got[i])
      if (got[i].kind == kind && got[i].cyc >= from) return i;
    return -1;
  endfunction

  function automatic int ev_cyc(input int i);
    return (i < 0) ? -1 : got[i].cyc;
  endfunction

  function automatic int ev_data(input int i);
    return (i < 0) ? -1 : got[i].data;
  endfunction

  // ---------------- reference model ----------------
  // synchronised line as seen in cycle t (two-cycle latency, reset to 1)
  function automatic logic rxs(input int t);
    if (t < 2) return 1'b1;
    if (rst_rec[t-1] === 1'b1 || rst_rec[t-2] === 1'b1) return 1'b1;
    return line_rec[t-2];
  endfunction

  // 2-of-3 vote over the three cycles ending at evaluation cycle te
  function automatic logic vote(input int te);
    int ones;
    ones = int'(rxs(te - 2)) + int'(rxs(te - 1)) + int'(rxs(te));
    return (ones >= 2) ? 1'b1 : 1'b0;
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int u = a; u <= b && u < MAXC; u++)
      if (rst_rec[u] === 1'b1) return u;
    return -1;
  endfunction

  task automatic build_model(input int nrec);
    int t, t0, ts, r, u;
    logic [7:0] d;
    logic pb, sb;
    t = 0;
    while (t < nrec) begin
      if (rst_rec[t] === 1'b1 || rxs(t) !== 1'b0) begin
        t++;
        continue;
      end
      t0 = t;
      ts = t0 + STOP_K * C + H + 1;
      r = first_rst(t0, t0 + H + 1);
      if (r >= 0) begin
        t = r + 1;
        continue;
      end
      if (vote(t0 + H + 1) == 1'b1) begin
        t = t0 + H + 2;
        continue;
      end
      if (ts + 1 >= nrec) break;
      r = first_rst(t0, ts);
      if (r >= 0) begin
        t = r + 1;
        continue;
      end
      for (int k = 1; k <= 8; k++) d[k-1] = vote(t0 + k * C + H + 1);
      pb = PAR ? vote(t0 + 9 * C + H + 1) : (^d);
      sb = vote(ts);
      if (sb == 1'b1) begin
        if ((^{d, pb}) == 1'b0) exp_q.push_back('{cyc: ts + 1, kind: K_BYTE, data: int'(d)});
        else                    exp_q.push_back('{cyc: ts + 1, kind: K_PERR, data: 0});
        t = ts + 1;
      end else begin
        exp_q.push_back('{cyc: ts + 1, kind: K_FERR, data: 0});
        if (d == 8'h00) exp_q.push_back('{cyc: ts + 1, kind: K_BRK, data: 0});
        t = nrec;
        for (u = ts + 1; u < nrec; u++) begin
          if (rst_rec[u] === 1'b1 || rxs(u) == 1'b1) begin
            t = u + 1;
            break;
          end
        end
      end
    end
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int p, q, e1, e2, nrec;
    logic [7:0] rb;
    rst  = 1'b1;
    i_rx = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_byte",   o_byte, 8'h00);
    check("rst_byte_v", o_byte_v, 1'b0);
    check("rst_ferr",   o_frame_err, 1'b0);
    check("rst_break",  o_break, 1'b0);
    check("rst_perr",   o_parity_err, 1'b0);
    check("rst_busy",   o_busy, 1'b0);
    tick(20);

    // good byte 'A'; pin edge in cycle p, t0 = p + 2
    p = cyc;
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    tick(200);
    e1 = first_ev(K_BYTE, p);
    check("A_time", ev_cyc(e1), p + 2 + STOP_K * C + H + 2);
    check("A_data", ev_data(e1), 8'h41);
    check("A_errs", count_ev(K_FERR, p, cyc) + count_ev(K_BRK, p, cyc) + count_ev(K_PERR, p, cyc), 0);

    // 20-cycle glitch: false start, busy back low at t0 + H + 2
    p = cyc;
    i_rx = 1'b0;
    tick(3);
    check("glitch_busy_hi", o_busy, 1'b1);
    tick(17);
    i_rx = 1'b1;
    tick(35);
    check("glitch_busy_late", o_busy, 1'b1);
    tick(1);
    check("glitch_busy_lo", o_busy, 1'b0);
    tick(250);
    check("glitch_strobes", count_ev(K_ANY, p, cyc), 0);

    // back-to-back 'j','k' with no idle gap
    p = cyc;
    send_frame(8'h6A, 1'b1, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b1, 1'b0, 1'b0);
    tick(300);
    e1 = first_ev(K_BYTE, p);
    e2 = first_ev(K_BYTE, ev_cyc(e1) + 1);
    check("bb_j", ev_data(e1), 8'h6A);
    check("bb_k", ev_data(e2), 8'h6B);
    check("bb_space", ev_cyc(e2) - ev_cyc(e1), NBITS * C);

    // 0x55 with stop low: framing error, no byte, o_byte holds
    p = cyc;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    i_rx = 1'b1;
    tick(300);
    check("fe_ferr", count_ev(K_FERR, p, cyc), 1);
    check("fe_byte", count_ev(K_BYTE, p, cyc), 0);
    check("fe_break", count_ev(K_BRK, p, cyc), 0);
    check("fe_hold", o_byte, 8'h6B);

    // line low 30 bit times: one break, then 0x20 received
    p = cyc;
    i_rx = 1'b0;
    tick(30 * C);
    i_rx = 1'b1;
    tick(C);
    q = cyc;
    check("brk_ferr", count_ev(K_FERR, p, q), 1);
    check("brk_break", count_ev(K_BRK, p, q), 1);
    send_frame(8'h20, 1'b1, 1'b0, 1'b0);
    tick(300);
    e1 = first_ev(K_BYTE, q);
    check("brk_after", ev_data(e1), 8'h20);

    // reset during data bit 3 of 0x6C; the transmitter side is reset too
    p = cyc;
    i_rx = 1'b0;
    tick(C);
    i_rx = 1'b0; tick(C);
    i_rx = 1'b0; tick(C);
    i_rx = 1'b1; tick(C);
    i_rx = 1'b1; tick(50);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_busy", o_busy, 1'b0);
    tick(2 * C);
    send_frame(8'h68, 1'b1, 1'b0, 1'b0);
    tick(300);
    check("rst_mid_count", count_ev(K_BYTE, p, cyc), 1);
    e1 = first_ev(K_BYTE, p);
    check("rst_mid_data", ev_data(e1), 8'h68);

`ifdef UART_RX_PARITY_EN
    p = cyc;
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    tick(200);
    check("par_ok", count_ev(K_BYTE, p, cyc), 1);
    p = cyc;
    send_frame(8'h41, 1'b1, 1'b1, 1'b0);
    tick(200);
    check("par_bad_perr", count_ev(K_PERR, p, cyc), 1);
    check("par_bad_byte", count_ev(K_BYTE, p, cyc), 0);
`endif

    // random frames with bit-length jitter, bad stops, glitches and gaps
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(4, 0) != 0) ? 1'b1 : 1'b0,
                 (PAR && $urandom_range(3, 0) == 0) ? 1'b1 : 1'b0, 1'b1);
      i_rx = 1'b1;
      tick(int'($urandom_range(300, 0)));
      if ($urandom_range(5, 0) == 0) begin
        i_rx = 1'b0;
        tick(int'($urandom_range(40, 1)));
        i_rx = 1'b1;
        tick(C);
      end
    end
    tick(3 * C);

    nrec = cyc;
    build_model(nrec);
    check("ev_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("ev%0d_cyc", i),  got[i].cyc,  exp_q[i].cyc);
      check($sformatf("ev%0d_kind", i), got[i].kind, exp_q[i].kind);
      check($sformatf("ev%0d_data", i), got[i].data, exp_q[i].data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
